gauss_window_3x3: RTL
=====================

# gauss_window_3x3

Streaming 3x3 window generator that sits directly upstream of the Gaussian filter datapath. It accepts a raster-order pixel stream, one pixel per handshake, and keeps the two previous image rows in line buffers. For every interior pixel it presents the full 3x3 neighbourhood as one flattened word, which the Gaussian kernel consumes. It also pulses a frame-complete flag that drives the top-level `done` path.

## Interface
Parameters:
- IMG_W, 128, image width in pixels (>= 3)
- IMG_H, 128, image height in pixels (>= 3)
- PIX_W, 8, bits per pixel

Ports:
- clk  input  1  single clock domain; all logic on rising edge
- rst  input  1  reset, asynchronous and active-low
- in_valid  input  1  upstream pixel valid
- in_sof  input  1  start of frame; qualified by in_valid, marks pixel (0,0)
- in_pixel  input  PIX_W  pixel value
- in_ready  output  1  block can accept a pixel this cycle
- out_valid  output  1  window valid
- out_ready  input  1  downstream (Gaussian kernel) accepts the window
- out_win  output  9*PIX_W  window; element (r,c) at [PIX_W*(3*r+c) +: PIX_W]; r=0 is the oldest (top) row, c=0 is the leftmost column
- frame_done  output  1  one-cycle pulse when the last window of a frame is accepted

## Operation
- Accept condition: in_valid && in_ready, with in_ready = !out_valid || out_ready (single output register, full-throughput pass-through).
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next accepted pixel.
  - On accept, col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to (0,0).
- in_sof on an accepted pixel forces that pixel to position (0,0), and the counters continue from (0,1). A mid-frame in_sof silently restarts the frame and produces no frame_done for the aborted frame.
- Line buffers lb0 and lb1 are IMG_W entries each and are indexed by col. On accept at column c:
  - tap1 = lb0[c] (row-1) and tap2 = lb1[c] (row-2), read before write.
  - Then lb1[c] <= tap1 and lb0[c] <= in_pixel.
- Window register, on accept:
  - Columns shift left: (r,0) <= (r,1) and (r,1) <= (r,2).
  - The new column 2 is loaded as (0,2)=tap2, (1,2)=tap1, (2,2)=in_pixel.
- Output: on accept of the pixel at (row,col) with row >= 2 and col >= 2, out_valid <= 1.
  - Otherwise, on a downstream accept (out_valid && out_ready) with no new qualifying window, out_valid <= 0.
- Only interior windows are produced: (IMG_W-2)*(IMG_H-2) windows per frame. There is no border replication and no end-of-frame flush.
- frame_done: asserted for exactly one cycle, the cycle after the out_valid && out_ready handshake of the window from pixel (IMG_H-1, IMG_W-1).
- Pixel arithmetic: pure data movement, no width change.

## Timing
- Reset values: out_valid=0, frame_done=0, out_win=0, row=col=0. Line buffer contents are not reset; an interior window only reads rows written in the current frame.
- in_ready is combinational from out_valid and out_ready. While out_valid=0 it is 1 immediately after reset.
- Latency: a window becomes valid 1 cycle after the accept of its bottom-right pixel.
- Backpressure: while out_valid && !out_ready, in_ready=0, and out_win and all state hold stable.
- Simultaneous downstream accept and new input accept: the new window replaces the old one in the same edge, with no bubble.
- A reset asserted mid-frame clears all outputs and counters immediately (asynchronous). The next accepted pixel is treated as (0,0).

## Structure
- Shared package img_pkg: PIX_W and IMG_W/IMG_H defaults, a pixel_t typedef, and a WIN_IDX(r,c) constant function giving the bit offset of each window element. The Gaussian kernel stage imports the same package.
- Sub-module line_buffer: an IMG_W x PIX_W register array with a combinational read at addr and a synchronous write at addr. It is instantiated twice (lb0, lb1).

## Test plan
- IMG_W=IMG_H=4; stream pixel=16*r+c, in_sof on the first pixel, out_ready=1 → 4 windows. The first is {0,1,2,16,17,18,32,33,34} and the last is {17,18,19,33,34,35,49,50,51}. frame_done pulses once, 1 cycle after the last handshake.
- Same stream with out_ready held 0 for 5 cycles after the first out_valid → in_ready=0 throughout, out_win stable, no pixel lost; total output is still 4 windows with correct values.
- Back-to-back frames with continuous in_valid → 8 windows, two frame_done pulses, and the second frame's first window is {0,1,2,16,17,18,32,33,34}.
- in_sof asserted at pixel (2,1) of frame 1, then a full frame follows → no frame_done for the aborted frame; the next 4 windows match the 4x4 reference values.
- rst pulled low at pixel (3,0) → out_valid and frame_done go to 0 within the same cycle. After release, a full frame yields exactly 4 correct windows.
- Random in_valid/out_ready gaps on a 6x5 image (values mod 256) → 12 windows, bit-exact against a software 3x3 neighbourhood model.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image constants and window layout helpers.
// Imported by the window generator and the Gaussian kernel stage.
package img_pkg;

  localparam int PIX_W = 8;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;

  typedef logic [PIX_W-1:0] pixel_t;

  function automatic int WIN_IDX(
    input int r,
    input int c,
    input int pw = PIX_W
  );
    return pw * (3 * r + c);
  endfunction

endpackage

// File: rtl/gauss_window_3x3_if.sv
// Pixel-in / window-out handshake bundle for the 3x3 window generator.
// master drives pixels and takes windows; slave is the window block.
interface gauss_window_3x3_if #(
  parameter int PIX_W = 8
);
  import img_pkg::*;

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_pixel;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [9*PIX_W-1:0] out_win;
  logic             frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    output out_ready,
    input  in_ready, out_valid,
    input  out_win, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    input  out_ready,
    output in_ready, out_valid,
    output out_win, frame_done
  );

endinterface

// File: rtl/gauss_window_3x3_line_buffer.sv
// One image row of pixels: combinational read, synchronous write.
// Contents are deliberately not reset; readers only see current-frame rows.
module line_buffer #(
  parameter int DEPTH = 128,
  parameter int PIX_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);
  import img_pkg::*;

  logic [PIX_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/gauss_window_3x3.sv
// Raster-stream 3x3 window generator feeding the Gaussian kernel.
// Two line buffers supply the rows above; only interior windows are emitted.
module gauss_window_3x3 #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_pixel,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_win,
  output logic               frame_done
);
  import img_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]    col, ecol, col_n;
  logic [RW-1:0]    row, erow, row_n;
  logic             accept, col_last, row_last;
  logic             win_hit, last_win;
  logic [PIX_W-1:0] tap1, tap2;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // sof overrides the counters for the pixel it marks
  assign ecol = in_sof ? '0 : col;
  assign erow = in_sof ? '0 : row;

  assign col_last = (ecol == CW'(IMG_W - 1));
  assign row_last = (erow == RW'(IMG_H - 1));
  assign win_hit  = (erow >= RW'(2)) && (ecol >= CW'(2));

  always_comb begin
    col_n = ecol + CW'(1);
    row_n = erow;
    if (col_last) begin
      col_n = '0;
      row_n = row_last ? '0 : erow + RW'(1);
    end
  end

  line_buffer #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (ecol),
    .wdata (in_pixel),
    .rdata (tap1)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (ecol),
    .wdata (tap1),
    .rdata (tap2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      out_win    <= '0;
      last_win   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && last_win;
      if (accept) begin
        col <= col_n;
        row <= row_n;
        for (int r = 0; r < 3; r++) begin
          out_win[WIN_IDX(r, 0, PIX_W) +: PIX_W] <=
            out_win[WIN_IDX(r, 1, PIX_W) +: PIX_W];
          out_win[WIN_IDX(r, 1, PIX_W) +: PIX_W] <=
            out_win[WIN_IDX(r, 2, PIX_W) +: PIX_W];
        end
        out_win[WIN_IDX(0, 2, PIX_W) +: PIX_W] <= tap2;
        out_win[WIN_IDX(1, 2, PIX_W) +: PIX_W] <= tap1;
        out_win[WIN_IDX(2, 2, PIX_W) +: PIX_W] <= in_pixel;
      end
      if (accept && win_hit) begin
        out_valid <= 1'b1;
        last_win  <= col_last && row_last;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
